// File: rtl/gmii_rx_stim.sv
// GMII receive-side traffic generator: drives preamble, SFD, a deterministic payload
// and an inter-frame gap on NUM_PORTS ports in lockstep, with optional rxer injection.
module gmii_rx_stim #(
    parameter int NUM_PORTS = 4,
    parameter int LEN_W     = 11,
    parameter int PRE_LEN   = 7,
    parameter int IFG_MIN   = 12
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   err_inject,
    input  logic [NUM_PORTS-1:0]   port_en,
    input  logic [LEN_W-1:0]       frame_len,
    input  logic [7:0]             ifg_len,
    input  logic [15:0]            num_frames,
    output logic [NUM_PORTS-1:0]   rxdv,
    output logic [NUM_PORTS-1:0]   rxer,
    output logic [8*NUM_PORTS-1:0] rxd,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            frames_sent
);

    localparam int CNT_W     = (LEN_W > 8) ? LEN_W : 8;
    // A zero-cycle gap cannot be represented by the state machine, so the floor is at least 1.
    localparam int GAP_FLOOR = (IFG_MIN < 1) ? 1 : IFG_MIN;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        PAY,
        IFG
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [CNT_W-1:0]     cnt;
    logic [NUM_PORTS-1:0] en_q;
    logic [LEN_W-1:0]     len_q;
    logic [7:0]           gap_q;
    logic [15:0]          num_q;
    logic                 stop_pend;
    logic                 err_armed;
    logic                 finishing;

    logic                 pre_last;
    logic                 pay_last;
    logic                 ifg_last;
    logic                 run_over;
    logic                 err_fire;

    logic [NUM_PORTS-1:0]   rxdv_nxt;
    logic [NUM_PORTS-1:0]   rxer_nxt;
    logic [8*NUM_PORTS-1:0] rxd_nxt;
    logic                   busy_nxt;
    logic                   done_nxt;

    assign pre_last = (cnt == CNT_W'(PRE_LEN - 1));
    assign pay_last = (cnt == CNT_W'(len_q) - CNT_W'(1));
    assign ifg_last = (cnt == CNT_W'(gap_q) - CNT_W'(1));
    assign run_over = stop_pend || ((num_q != 16'd0) && (frames_sent == num_q));
    assign err_fire = (state == PAY) && (cnt == '0) && err_armed;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)    state_nxt = PRE;
            PRE:  if (pre_last) state_nxt = SFD;
            SFD:                state_nxt = PAY;
            PAY:  if (pay_last) state_nxt = IFG;
            IFG:  if (ifg_last) state_nxt = run_over ? IDLE : PRE;
            default:            state_nxt = IDLE;
        endcase
    end

    // Counter restarts on every state change, so each phase counts its own cycles from zero.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt         <= '0;
            en_q        <= '0;
            len_q       <= LEN_W'(1);
            gap_q       <= 8'(GAP_FLOOR);
            num_q       <= '0;
            frames_sent <= '0;
            stop_pend   <= 1'b0;
            err_armed   <= 1'b0;
            finishing   <= 1'b0;
        end else begin
            finishing <= (state == IFG) && (state_nxt == IDLE);

            if ((state == IDLE) && start) begin
                en_q        <= port_en;
                len_q       <= (frame_len == '0) ? LEN_W'(1) : frame_len;
                gap_q       <= (ifg_len < 8'(GAP_FLOOR)) ? 8'(GAP_FLOOR) : ifg_len;
                num_q       <= num_frames;
                frames_sent <= '0;
                cnt         <= '0;
            end else begin
                if (state != state_nxt) begin
                    cnt <= '0;
                end else if (state != IDLE) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if ((state == PAY) && pay_last) begin
                    frames_sent <= frames_sent + 16'd1;
                end
            end

            if (state_nxt == IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop && (state != IDLE)) begin
                stop_pend <= 1'b1;
            end

            err_armed <= (err_armed | err_inject) & ~err_fire;
        end
    end

    // Output values are computed from the current phase and registered one cycle later.
    always_comb begin
        rxdv_nxt = '0;
        rxer_nxt = '0;
        rxd_nxt  = '0;
        busy_nxt = (state != IDLE);
        done_nxt = finishing;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (en_q[p]) begin
                case (state)
                    PRE: begin
                        rxdv_nxt[p]       = 1'b1;
                        rxd_nxt[8*p +: 8] = 8'h55;
                    end
                    SFD: begin
                        rxdv_nxt[p]       = 1'b1;
                        rxd_nxt[8*p +: 8] = 8'hD5;
                    end
                    PAY: begin
                        rxdv_nxt[p]       = 1'b1;
                        rxer_nxt[p]       = err_fire;
                        rxd_nxt[8*p +: 8] = cnt[7:0] + 8'(64 * p);
                    end
                    default: begin
                        rxdv_nxt[p]       = 1'b0;
                        rxd_nxt[8*p +: 8] = 8'h00;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rxdv <= '0;
            rxer <= '0;
            rxd  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            rxdv <= rxdv_nxt;
            rxer <= rxer_nxt;
            rxd  <= rxd_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

endmodule
